// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT ping-pong frame buffer: address width
// helper, reader state encoding and index bit-reversal.
package fft_buf_pkg;

  localparam int MAX_IDX_W = 16;
  localparam int SEL_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Reverses the low 'width' bits of idx; bits above width come back as zero.
  function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] idx,
                                                  input int width);
    logic [MAX_IDX_W-1:0] rev;
    logic [SEL_W-1:0]     dst;
    logic [SEL_W-1:0]     src;
    rev = '0;
    for (int i = 0; i < MAX_IDX_W; i++) begin
      if (i < width) begin
        dst      = SEL_W'(i);
        src      = SEL_W'(width - 1 - i);
        rev[dst] = idx[src];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_frame_buffer_sdp_ram.sv
// Simple dual-port RAM, single clock, one write port and one registered
// read port. Only the read register is reset; the array is not.
module sdp_ram
  import fft_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW   = addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: the writer fills two banks alternately, the reader
// bursts one full bank per request in natural or bit-reversed order.
//
// state | meaning
// IDLE  | waiting for Request with the read bank full
// READ  | issuing one RAM read per cycle for the current frame
module fft_frame_buffer
  import fft_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 32,
  parameter int NUM_CH     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  output logic                         wr_full,
  output logic                         overflow,
  input  logic                         Request,
  input  logic                         rd_bitrev,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         data_vaild,
  output logic                         data_tlast
);

  localparam int IDX_W = addr_w(FRAME_LEN);
  localparam int W     = NUM_CH * DATA_WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  rd_state_e        state_q, state_d;
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [IDX_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             mode_q, mode_d;
  logic             vld_q, tlast_q;
  logic             wr_go, last_issue;
  logic [IDX_W-1:0] rd_idx;

  assign wr_go      = wr_en && !bank_full_q[wb_q];
  assign last_issue = (state_q == READ) && (rcnt_q == IDX_LAST);
  assign wr_full    = bank_full_q[wb_q];
  assign overflow   = wr_en && bank_full_q[wb_q];
  assign rd_idx     = mode_q ? IDX_W'(bitrev(MAX_IDX_W'(rcnt_q), IDX_W)) : rcnt_q;

  // Writer sets and reader clears always hit different bank bits.
  always_comb begin
    wb_d        = wb_q;
    wcnt_d      = wcnt_q;
    bank_full_d = bank_full_q;
    if (wr_go) begin
      wcnt_d = wcnt_q + IDX_W'(1);
      if (wcnt_q == IDX_LAST) begin
        bank_full_d[wb_q] = 1'b1;
        wb_d              = ~wb_q;
        wcnt_d            = '0;
      end
    end
    if (last_issue) bank_full_d[rb_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    rb_d    = rb_q;
    rcnt_d  = rcnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (Request && bank_full_q[rb_q]) begin
          state_d = READ;
          rcnt_d  = '0;
          mode_d  = rd_bitrev;
        end
      end
      READ: begin
        rcnt_d = rcnt_q + IDX_W'(1);
        if (rcnt_q == IDX_LAST) begin
          rb_d   = ~rb_q;
          rcnt_d = '0;
          if (Request && bank_full_q[~rb_q]) mode_d = rd_bitrev;
          else                               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      bank_full_q <= '0;
      mode_q      <= 1'b0;
      vld_q       <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      bank_full_q <= bank_full_d;
      mode_q      <= mode_d;
      vld_q       <= (state_q == READ);
      tlast_q     <= last_issue;
    end
  end

  assign data_vaild = vld_q;
  assign data_tlast = tlast_q;

  sdp_ram #(
    .WIDTH (W),
    .DEPTH (2 * FRAME_LEN)
  ) u_ram (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (wr_go),
    .waddr_i ({wb_q, wcnt_q}),
    .wdata_i (wr_data),
    .re_i    (state_q == READ),
    .raddr_i ({rb_q, rd_idx}),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: table-driven frame reads plus
// sequences for overflow, back-to-back streaming and reset mid-burst.
module tb_fft_frame_buffer;

  localparam int DW = 32;
  localparam int FL = 32;
  localparam int NC = 4;
  localparam int W  = DW * NC;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         Request = 1'b0;
  logic         rd_bitrev = 1'b0;
  logic         wr_full, overflow, data_vaild, data_tlast;
  logic [W-1:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_frame_buffer #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .NUM_CH     (NC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_full    (wr_full),
    .overflow   (overflow),
    .Request    (Request),
    .rd_bitrev  (rd_bitrev),
    .rd_data    (rd_data),
    .data_vaild (data_vaild),
    .data_tlast (data_tlast)
  );

  typedef struct {
    string name;
    logic  bitrev;
    int    order[FL];
  } frame_vec_t;

  frame_vec_t   vecs[2];
  logic [W-1:0] cap_d[FL];
  logic         cap_t[FL];
  logic         cap_v[FL];
  logic         ovf_at[128];
  logic         full_at[128];

  function automatic logic [W-1:0] pack(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = DW'(100 * k + v);
    return r;
  endfunction

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_seq(input int start, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = pack(start + j);
      #1;
      ovf_at[start + j]  = overflow;
      full_at[start + j] = wr_full;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_request(input logic br);
    @(negedge clk);
    Request   = 1'b1;
    rd_bitrev = br;
    @(negedge clk);
    Request   = 1'b0;
    rd_bitrev = 1'b0;
  endtask

  // Advances one cycle, waits (bounded) for valid, then samples FL beats.
  task automatic capture_frame(input string tag, output int wait_cyc);
    wait_cyc = 0;
    @(negedge clk);
    while (!data_vaild && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_b({tag, " start"}, data_vaild, 1'b1);
    for (int b = 0; b < FL; b++) begin
      if (b > 0) @(negedge clk);
      cap_v[b] = data_vaild;
      cap_d[b] = rd_data;
      cap_t[b] = data_tlast;
    end
  endtask

  task automatic verify_frame(input string tag, input int exp_v[FL]);
    for (int b = 0; b < FL; b++) begin
      check_b($sformatf("%s vld[%0d]", tag, b), cap_v[b], 1'b1);
      check_w($sformatf("%s data[%0d]", tag, b), cap_d[b], pack(exp_v[b]));
      check_b($sformatf("%s tlast[%0d]", tag, b), cap_t[b], b == FL - 1);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  wcyc;
    int  e[FL];
    int  ovf_cnt;
    logic seen;

    vecs[0].name   = "natural";
    vecs[0].bitrev = 1'b0;
    for (int i = 0; i < FL; i++) vecs[0].order[i] = i;
    vecs[1].name   = "bitrev";
    vecs[1].bitrev = 1'b1;
    vecs[1].order  = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                       1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    // Reset and idle requests
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_b("rst wr_full", wr_full, 1'b0);
    check_b("rst overflow", overflow, 1'b0);
    check_b("rst vld", data_vaild, 1'b0);
    check_b("rst tlast", data_tlast, 1'b0);
    check_w("rst rd_data", rd_data, '0);
    seen = 1'b0;
    Request = 1'b1;
    repeat (50) begin
      @(negedge clk);
      seen = seen | data_vaild;
    end
    Request = 1'b0;
    check_b("idle request no vld", seen, 1'b0);

    // Table-driven single-frame reads
    for (int v = 0; v < 2; v++) begin
      write_seq(0, FL);
      pulse_request(vecs[v].bitrev);
      check_b({vecs[v].name, " no early vld"}, data_vaild, 1'b0);
      capture_frame(vecs[v].name, wcyc);
      check_i({vecs[v].name, " latency"}, wcyc, 0);
      verify_frame(vecs[v].name, vecs[v].order);
      @(negedge clk);
      check_b({vecs[v].name, " burst end"}, data_vaild, 1'b0);
    end

    // Overflow: 80 samples into 64 slots
    write_seq(0, 80);
    ovf_cnt = 0;
    for (int j = 0; j < 80; j++) if (ovf_at[j]) ovf_cnt++;
    check_i("ovf count", ovf_cnt, 16);
    check_b("full at 63", full_at[63], 1'b0);
    check_b("full at 64", full_at[64], 1'b1);
    check_b("ovf at 63", ovf_at[63], 1'b0);
    check_b("ovf at 64", ovf_at[64], 1'b1);
    check_b("ovf at 79", ovf_at[79], 1'b1);
    for (int f = 0; f < 2; f++) begin
      pulse_request(1'b0);
      capture_frame($sformatf("ovf rd%0d", f), wcyc);
      for (int b = 0; b < FL; b++) e[b] = 32 * f + b;
      verify_frame($sformatf("ovf rd%0d", f), e);
    end

    // Back-to-back streaming with both banks prefilled
    write_seq(0, 2 * FL);
    ovf_cnt = 0;
    @(negedge clk);
    Request   = 1'b1;
    rd_bitrev = 1'b0;
    fork
      begin
        int nxt   = 2 * FL;
        int guard = 0;
        while (nxt < 3 * FL && guard < 400) begin
          @(negedge clk);
          guard++;
          if (!wr_full) begin
            wr_en   = 1'b1;
            wr_data = pack(nxt);
            nxt++;
          end else begin
            wr_en = 1'b0;
          end
          #1;
          if (overflow) ovf_cnt++;
        end
        @(negedge clk);
        wr_en = 1'b0;
      end
      begin
        int wc;
        for (int f = 0; f < 3; f++) begin
          capture_frame($sformatf("b2b f%0d", f), wc);
          if (f == 1) check_i("b2b gap", wc, 0);
          for (int b = 0; b < FL; b++) e[b] = 32 * f + b;
          verify_frame($sformatf("b2b f%0d", f), e);
        end
      end
    join
    Request = 1'b0;
    check_i("b2b ovf count", ovf_cnt, 0);

    // Reset mid-burst
    write_seq(0, FL);
    pulse_request(1'b0);
    wcyc = 0;
    while (!data_vaild && wcyc < 200) begin
      @(negedge clk);
      wcyc++;
    end
    check_b("mid vld seen", data_vaild, 1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_b("mid rst vld", data_vaild, 1'b0);
    check_b("mid rst tlast", data_tlast, 1'b0);
    check_w("mid rst rd_data", rd_data, '0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    Request = 1'b1;
    seen    = 1'b0;
    for (int j = 0; j < FL - 1; j++) begin
      @(negedge clk);
      seen    = seen | data_vaild;
      wr_en   = 1'b1;
      wr_data = pack(j);
    end
    @(negedge clk);
    seen    = seen | data_vaild;
    wr_en   = 1'b1;
    wr_data = pack(FL - 1);
    check_b("post rst no vld", seen, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    capture_frame("post rst", wcyc);
    for (int b = 0; b < FL; b++) e[b] = b;
    verify_frame("post rst", e);
    Request = 1'b0;
    @(negedge clk);
    check_b("post rst end", data_vaild, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
Single-clock, ping-pong frame buffer feeding the FFT core.
- Write side accepts a continuous multi-lane sample stream and fills two banks of FRAME_LEN samples in alternation.
- Read side, on Request, bursts one complete frame per Request with valid/tlast framing, in either natural or bit-reversed address order.
- Successor to the dual-clock FIFO_RAM frame reader. Adds a channel count, runtime bit-reverse mode, overflow detection and back-to-back frame readout.

Parameters:
- DATA_WIDTH, 32, bits per lane sample.
- FRAME_LEN, 32, samples per frame per lane; must be a power of 2 and at least 4.
- NUM_CH, 1, parallel lanes. Lanes share one address; each lane is packed in a DATA_WIDTH slice, lane 0 in the LSBs.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; one sample per lane per cycle.
- wr_data  in  NUM_CH*DATA_WIDTH  input samples.
- wr_full  out  1  high when the current write bank is full, i.e. both banks are full.
- overflow  out  1  one-cycle pulse when wr_en arrives while wr_full is high; that sample is dropped.
- Request  in  1  level-sensitive read request.
- rd_bitrev  in  1  read-order select, latched at burst start: 0 = natural, 1 = bit-reversed.
- rd_data  out  NUM_CH*DATA_WIDTH  registered read data.
- data_vaild  out  1  rd_data is valid this cycle.
- data_tlast  out  1  last sample of the frame, coincident with data_vaild.

Behaviour:
- Reset:
  - Reset is asynchronous. All outputs go to 0, as do wb, rb, wcnt, rcnt and bank_full[1:0]. The FSM enters IDLE.
  - RAM contents are not reset.
- Storage:
  - One simple dual-port RAM, 2*FRAME_LEN deep, NUM_CH*DATA_WIDTH wide.
  - Address = {bank bit, log2(FRAME_LEN)-bit index}.
- Writer:
  - Write occurs when wr_en=1 and bank_full[wb]=0: mem[{wb,wcnt}] <= wr_data, then wcnt++.
  - At wcnt==FRAME_LEN-1 the write also sets bank_full[wb], toggles wb and resets wcnt to 0.
  - When wr_en=1 and bank_full[wb]=1: no write, overflow=1 for that cycle, wcnt and wb unchanged.
  - wr_full = bank_full[wb], combinational from registers.
- Reader FSM, states IDLE and READ:
  - IDLE -> READ when Request=1 and bank_full[rb]=1. On this transition rcnt=0 and rd_bitrev is latched into mode.
  - In READ the read address is {rb, mode ? bitrev(rcnt) : rcnt}, and rcnt increments each cycle.
  - At the last issue (rcnt==FRAME_LEN-1): clear bank_full[rb] and toggle rb.
    - If Request=1 and the other bank is full, stay in READ with rcnt=0 and re-latch mode. This gives back-to-back frames with no valid gap.
    - Otherwise go to IDLE.
- Output pipeline:
  - RAM read is registered with 1-cycle latency.
  - data_vaild = (state==READ) delayed 1 cycle.
  - data_tlast = last-issue delayed 1 cycle.
- Latency:
  - If Request is sampled high at edge E0 with a full bank, data_vaild is high for FRAME_LEN consecutive cycles starting after edge E0+1.
  - A frame completed at write edge W is requestable at edge W+1.
- Simultaneous events:
  - Writer-set and reader-clear of bank_full always target different bits, because wb never points at a full bank and rb always does. Both take effect in the same cycle.
  - The write bank and read bank always differ, so there is no RAM address collision.
- Request behaviour:
  - Request low mid-burst does not abort; the burst completes.
  - Request high with no full bank: stay in IDLE, no output activity.
- Reset mid-burst: outputs drop to 0 immediately; the partial frame and all buffered frames are discarded.

Decomposition:
- Shared package/header fft_buf_pkg contains:
  - a clog2-based ADDR_W helper;
  - the reader state encoding (IDLE=0, READ=1);
  - a parametrised bitrev function over log2(FRAME_LEN) bits.
- One sub-module, sdp_ram: simple dual-port, single clock, one write port and one registered read port, parametrised in width and depth.
- Everything else (writer, reader FSM, output pipeline) lives in fft_frame_buffer.

Test Plan:
1. Reset: hold rst_n=0 for 5 cycles, then release -> all outputs 0, wr_full=0; with no writes, Request=1 for 50 cycles produces no data_vaild.
2. Natural order (FRAME_LEN=32, NUM_CH=4): write lane k = 100*k+i for i=0..31, then Request=1 for 1 cycle -> 32 valid beats, lane k = 100*k+i; data_tlast high only on i=31.
3. Bit-reverse (rd_bitrev=1): write 0..31, then Request -> output sequence 0,16,8,24,4,20,...,15,31; data_tlast high with 31.
4. Overflow: write 0..79 continuously with no Request -> wr_full rises after sample 63; overflow pulses exactly 16 times for samples 64..79. Two subsequent reads return 0..31 then 32..63.
5. Back-to-back: continuous writes, Request held high -> frames stream contiguously with no data_vaild gap between a tlast and the next frame's first beat; frame n carries values 32n..32n+31; overflow never asserts.
6. Reset mid-burst: assert rst_n=0 at beat 10 of a burst -> data_vaild, data_tlast and rd_data go to 0 asynchronously; after release, Request yields nothing until 32 new writes complete.
